// File: rtl/spectral_peak_finder.sv
// Frame-wide spectral peak tracker fed by the cordic rect-to-polar stage.
// Reports the strongest in-band bin plus its phase and neighbouring magnitudes.
module spectral_peak_finder #(
    parameter int unsigned FFT_LOG2   = 10,
    parameter int unsigned MAG_W      = 23,
    parameter int unsigned PH_W       = 23,
    parameter int unsigned MIN_BIN    = 1,
    parameter int unsigned MAX_BIN    = 511,
    parameter int unsigned MAG_THRESH = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_start,
    input  logic                rdy,
    input  logic [MAG_W-1:0]    mag_in,
    input  logic [PH_W-1:0]     phase_in,
    output logic                peak_valid,
    output logic                peak_found,
    output logic [FFT_LOG2-1:0] peak_bin,
    output logic [MAG_W-1:0]    peak_mag,
    output logic [PH_W-1:0]     peak_phase,
    output logic [MAG_W-1:0]    peak_mag_left,
    output logic [MAG_W-1:0]    peak_mag_right,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q, state_d;
    logic [FFT_LOG2-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0]    prev_q, prev_d;
    logic                found_q, found_d;
    logic [FFT_LOG2-1:0] bin_q, bin_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [MAG_W-1:0]    left_q, left_d;
    logic [MAG_W-1:0]    right_q, right_d;
    logic                pend_q, pend_d;

    logic                accept_c;
    logic                start_c;
    logic                qualify_c;
    logic                last_c;
    logic                ovr_c;
    logic [FFT_LOG2-1:0] cur_bin_c;
    logic [MAG_W-1:0]    prev_base_c;

    // Next-state and tracker update; a frame_start sample sees cleared trackers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        found_d     = found_q;
        bin_d       = bin_q;
        mag_d       = mag_q;
        ph_d        = ph_q;
        left_d      = left_q;
        right_d     = right_q;
        pend_d      = pend_q;
        last_c      = 1'b0;
        ovr_c       = 1'b0;
        start_c     = rdy && frame_start;
        accept_c    = rdy && (frame_start || (state_q == SCAN));
        cur_bin_c   = start_c ? '0 : cnt_q;
        prev_base_c = start_c ? '0 : prev_q;
        qualify_c   = (cur_bin_c >= FFT_LOG2'(MIN_BIN)) &&
                      (cur_bin_c <= FFT_LOG2'(MAX_BIN)) &&
                      (mag_in > MAG_W'(MAG_THRESH));

        if (start_c) begin
            ovr_c   = (state_q == SCAN) && (cnt_q != '0);
            found_d = 1'b0;
            bin_d   = '0;
            mag_d   = '0;
            ph_d    = '0;
            left_d  = '0;
            right_d = '0;
            pend_d  = 1'b0;
        end

        if (accept_c) begin
            state_d = SCAN;
            cnt_d   = cur_bin_c + FFT_LOG2'(1);
            prev_d  = mag_in;
            if (qualify_c && (!found_d || (mag_in > mag_d))) begin
                found_d = 1'b1;
                bin_d   = cur_bin_c;
                mag_d   = mag_in;
                ph_d    = phase_in;
                left_d  = prev_base_c;
                pend_d  = 1'b1;
            end else if (pend_d) begin
                right_d = mag_in;
                pend_d  = 1'b0;
            end
            if (cur_bin_c == '1) begin
                state_d = IDLE;
                last_c  = 1'b1;
            end
        end
    end

    // State, trackers and registered outputs; results load as the last bin lands.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            prev_q         <= '0;
            found_q        <= 1'b0;
            bin_q          <= '0;
            mag_q          <= '0;
            ph_q           <= '0;
            left_q         <= '0;
            right_q        <= '0;
            pend_q         <= 1'b0;
            peak_valid     <= 1'b0;
            peak_found     <= 1'b0;
            peak_bin       <= '0;
            peak_mag       <= '0;
            peak_phase     <= '0;
            peak_mag_left  <= '0;
            peak_mag_right <= '0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            found_q    <= found_d;
            bin_q      <= bin_d;
            mag_q      <= mag_d;
            ph_q       <= ph_d;
            left_q     <= left_d;
            right_q    <= right_d;
            pend_q     <= pend_d;
            peak_valid <= last_c;
            busy       <= (state_d == SCAN);
            overrun    <= ovr_c;
            if (last_c) begin
                peak_found     <= found_d;
                peak_bin       <= bin_d;
                peak_mag       <= mag_d;
                peak_phase     <= ph_d;
                peak_mag_left  <= left_d;
                peak_mag_right <= right_d;
            end
        end
    end

endmodule

// File: tb/tb_spectral_peak_finder.sv
// Directed bench for spectral_peak_finder: table of 16-bin frames plus
// early-restart and mid-frame reset sequences.
module tb_spectral_peak_finder;

    localparam int unsigned LOG2 = 4;
    localparam int unsigned NB   = 16;
    localparam int unsigned MW   = 23;
    localparam int unsigned PW   = 23;
    localparam int unsigned NV   = 6;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            frame_start;
    logic            rdy;
    logic [MW-1:0]   mag_in;
    logic [PW-1:0]   phase_in;
    logic            peak_valid;
    logic            peak_found;
    logic [LOG2-1:0] peak_bin;
    logic [MW-1:0]   peak_mag;
    logic [PW-1:0]   peak_phase;
    logic [MW-1:0]   peak_mag_left;
    logic [MW-1:0]   peak_mag_right;
    logic            busy;
    logic            overrun;

    spectral_peak_finder #(
        .FFT_LOG2(LOG2), .MAG_W(MW), .PH_W(PW),
        .MIN_BIN(1), .MAX_BIN(7), .MAG_THRESH(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .rdy(rdy),
        .mag_in(mag_in), .phase_in(phase_in), .peak_valid(peak_valid),
        .peak_found(peak_found), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .peak_phase(peak_phase), .peak_mag_left(peak_mag_left),
        .peak_mag_right(peak_mag_right), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0][MW-1:0] mag;
        int                    ph_bin;
        logic [PW-1:0]         ph_val;
        logic                  exp_found;
        logic [LOG2-1:0]       exp_bin;
        logic [MW-1:0]         exp_mag;
        logic [PW-1:0]         exp_phase;
        logic [MW-1:0]         exp_left;
        logic [MW-1:0]         exp_right;
    } vec_t;

    vec_t vecs [NV];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input int i, input logic [MW-1:0] dflt);
        for (int b = 0; b < NB; b++) vecs[i].mag[b] = dflt;
        vecs[i].ph_bin = -1;
        vecs[i].ph_val = '0;
    endtask

    task automatic expect_res(input int i, input logic f, input logic [LOG2-1:0] b,
                              input logic [MW-1:0] m, input logic [PW-1:0] p,
                              input logic [MW-1:0] l, input logic [MW-1:0] r);
        vecs[i].exp_found = f;
        vecs[i].exp_bin   = b;
        vecs[i].exp_mag   = m;
        vecs[i].exp_phase = p;
        vecs[i].exp_left  = l;
        vecs[i].exp_right = r;
    endtask

    function automatic logic [PW-1:0] phase_for(input int v, input int b);
        if (b == vecs[v].ph_bin) return vecs[v].ph_val;
        return PW'(b * 16 + 7);
    endfunction

    task automatic send(input logic fs, input logic [MW-1:0] m, input logic [PW-1:0] p);
        frame_start = fs;
        rdy         = 1'b1;
        mag_in      = m;
        phase_in    = p;
        @(posedge clk);
        #1;
        rdy         = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Feeds one full frame (rdy on alternate cycles) and checks the report.
    task automatic run_frame(input int v, input logic exp_ovr);
        logic early;
        early = 1'b0;
        for (int b = 0; b < NB; b++) begin
            send(b == 0, vecs[v].mag[b], phase_for(v, b));
            if (b == 0) begin
                chk("overrun_at_start", 32'(overrun), 32'(exp_ovr));
                chk("busy_after_bin0", 32'(busy), 32'(1));
            end
            if (b == 1) chk("overrun_one_cycle", 32'(overrun), 32'(0));
            if (b < NB - 1) begin
                if (peak_valid) early = 1'b1;
                idle();
            end
        end
        chk("no_early_valid", 32'(early), 32'(0));
        chk("peak_valid", 32'(peak_valid), 32'(1));
        chk("busy_falls", 32'(busy), 32'(0));
        chk("peak_found", 32'(peak_found), 32'(vecs[v].exp_found));
        chk("peak_bin", 32'(peak_bin), 32'(vecs[v].exp_bin));
        chk("peak_mag", 32'(peak_mag), 32'(vecs[v].exp_mag));
        chk("peak_phase", 32'(peak_phase), 32'(vecs[v].exp_phase));
        chk("peak_mag_left", 32'(peak_mag_left), 32'(vecs[v].exp_left));
        chk("peak_mag_right", 32'(peak_mag_right), 32'(vecs[v].exp_right));
    endtask

    initial begin
        logic seen_busy;
        logic seen_valid;

        // 0: single peak
        fill(0, 23'd10);
        vecs[0].mag[4] = 23'd400;
        vecs[0].mag[5] = 23'd1000;
        vecs[0].mag[6] = 23'd600;
        vecs[0].ph_bin = 5;
        vecs[0].ph_val = 23'h01234;
        expect_res(0, 1'b1, 4'd5, 23'd1000, 23'h01234, 23'd400, 23'd600);
        // 1: tie keeps the earlier bin
        fill(1, 23'd10);
        vecs[1].mag[3] = 23'd500;
        vecs[1].mag[6] = 23'd500;
        expect_res(1, 1'b1, 4'd3, 23'd500, 23'd55, 23'd10, 23'd10);
        // 2: out-of-band bins ignored; bin0 still feeds the left of bin1
        fill(2, 23'd5);
        vecs[2].mag[0]  = 23'd9000;
        vecs[2].mag[10] = 23'd9000;
        vecs[2].mag[2]  = 23'd50;
        expect_res(2, 1'b1, 4'd2, 23'd50, 23'd39, 23'd5, 23'd5);
        // 3: empty frame
        fill(3, 23'd0);
        expect_res(3, 1'b0, 4'd0, 23'd0, 23'd0, 23'd0, 23'd0);
        // 4: successive replacements, left is the previous best
        fill(4, 23'd5);
        vecs[4].mag[1] = 23'd100;
        vecs[4].mag[2] = 23'd200;
        vecs[4].mag[3] = 23'd300;
        vecs[4].mag[4] = 23'd50;
        expect_res(4, 1'b1, 4'd3, 23'd300, 23'd55, 23'd200, 23'd50);
        // 5: full-width magnitudes, peak at MAX_BIN, right from out-of-band bin
        fill(5, 23'd3);
        vecs[5].mag[6] = 23'h400000;
        vecs[5].mag[7] = 23'h7FFFFF;
        vecs[5].mag[8] = 23'd9;
        vecs[5].mag[9] = 23'h7FFFFF;
        expect_res(5, 1'b1, 4'd7, 23'h7FFFFF, 23'd119, 23'h400000, 23'd9);

        reset_n = 1'b0;
        frame_start = 1'b0;
        rdy = 1'b0;
        mag_in = '0;
        phase_in = '0;
        repeat (3) idle();
        chk("reset_valid", 32'(peak_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_bin", 32'(peak_bin), 32'(0));
        reset_n = 1'b1;
        idle();

        // table frames, back-to-back
        for (int v = 0; v < NV; v++) run_frame(v, 1'b0);

        // early restart: abort vector 0 at bin 8, new frame is vector 2
        idle();
        for (int b = 0; b < 8; b++) begin
            send(b == 0, vecs[0].mag[b], phase_for(0, b));
            idle();
        end
        run_frame(2, 1'b1);

        // mid-frame reset at bin 9
        idle();
        for (int b = 0; b < 9; b++) begin
            send(b == 0, vecs[0].mag[b], phase_for(0, b));
            idle();
        end
        reset_n = 1'b0;
        send(1'b0, vecs[0].mag[9], phase_for(0, 9));
        reset_n = 1'b1;
        chk("rst_mid_valid", 32'(peak_valid), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_found", 32'(peak_found), 32'(0));
        chk("rst_mid_bin", 32'(peak_bin), 32'(0));
        chk("rst_mid_mag", 32'(peak_mag), 32'(0));
        chk("rst_mid_phase", 32'(peak_phase), 32'(0));
        chk("rst_mid_left", 32'(peak_mag_left), 32'(0));
        chk("rst_mid_right", 32'(peak_mag_right), 32'(0));
        chk("rst_mid_overrun", 32'(overrun), 32'(0));
        seen_busy = 1'b0;
        seen_valid = 1'b0;
        for (int b = 0; b < 20; b++) begin
            send(1'b0, 23'd1000, 23'd1);
            if (busy) seen_busy = 1'b1;
            if (peak_valid) seen_valid = 1'b1;
            idle();
        end
        chk("rdy_only_no_busy", 32'(seen_busy), 32'(0));
        chk("rdy_only_no_valid", 32'(seen_valid), 32'(0));

        // recovery frame, then results must hold
        run_frame(0, 1'b0);
        repeat (3) idle();
        chk("hold_valid_low", 32'(peak_valid), 32'(0));
        chk("hold_bin", 32'(peak_bin), 32'(5));
        chk("hold_right", 32'(peak_mag_right), 32'(600));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spectral_peak_finder.md
Name: spectral_peak_finder

Overview:
- Sits directly downstream of the cordic rectangular-to-polar stage in the autotune pitch-detection path.
- Consumes one magnitude/phase sample per cordic rdy pulse, one sample per FFT bin in natural bin order.
- Tracks the strongest bin within a configurable search band across a full frame.
- At frame end, reports the peak bin, its magnitude and phase, and both neighbouring magnitudes for downstream interpolation and pitch estimation.

Parameters:
- FFT_LOG2, 10, log2 of bins per frame (N = 2^FFT_LOG2).
- MAG_W, 23, magnitude width; matches cordic x_out.
- PH_W, 23, phase width; matches cordic phase_out.
- MIN_BIN, 1, lowest bin eligible as peak.
- MAX_BIN, 511, highest bin eligible as peak. Must satisfy MIN_BIN <= MAX_BIN <= N-2.
- MAG_THRESH, 0, a bin qualifies only if its magnitude is strictly greater than this.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- frame_start, in, 1, qualifies the rdy sample as bin 0 of a new frame.
- rdy, in, 1, sample strobe from cordic rdy.
- mag_in, in, MAG_W, unsigned magnitude (cordic x_out).
- phase_in, in, PH_W, phase (cordic phase_out), passed through unmodified.
- peak_valid, out, 1, one-cycle pulse; result outputs updated.
- peak_found, out, 1, at least one bin qualified in the reported frame.
- peak_bin, out, FFT_LOG2, index of peak bin.
- peak_mag, out, MAG_W, magnitude at peak_bin.
- peak_phase, out, PH_W, phase at peak_bin.
- peak_mag_left, out, MAG_W, magnitude at peak_bin-1.
- peak_mag_right, out, MAG_W, magnitude at peak_bin+1.
- busy, out, 1, frame scan in progress.
- overrun, out, 1, one-cycle pulse; frame aborted by an early frame_start.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, state IDLE, bin counter 0, all trackers cleared. Applies mid-frame: the partial frame is discarded and no peak_valid is produced for it.
- States: IDLE, SCAN. A sample is accepted only on a cycle with rdy=1; frame_start without rdy is ignored.
- IDLE: rdy&&frame_start goes to SCAN, processing that sample as bin 0. rdy alone is ignored.
- SCAN:
  - Each accepted sample takes bin index = counter; counter increments, wrapping in the FFT_LOG2-bit width. Gaps in rdy are permitted and do not advance the counter.
  - busy=1 throughout SCAN.
- Qualification: a sample qualifies iff MIN_BIN <= bin <= MAX_BIN and mag_in > MAG_THRESH.
- Best update: a qualifying sample replaces the best iff there is no best yet, or mag_in > best_mag (strict compare, so ties keep the earlier bin).
  - On replace: best_bin, best_mag, best_phase latch the sample.
  - best_left latches the magnitude of the previously accepted sample (held in a prev-mag register for every accepted sample, in range or not).
  - right_pending is set to 1.
- Right capture: on any accepted sample where right_pending=1 and the sample does not itself replace the best, best_right latches mag_in and right_pending clears. If the sample does replace the best, the new best's left is the old best's magnitude.
- Frame end: when the sample at bin N-1 is accepted, it is processed normally, including any pending right capture. On the next cycle:
  - peak_valid=1 for exactly one cycle.
  - Result outputs load from the trackers; state returns to IDLE; busy=0.
  - Result outputs hold until the next peak_valid or reset.
- No qualifying bin in the frame: peak_found=0; peak_bin, peak_mag, peak_phase, peak_mag_left and peak_mag_right are all 0.
- frame_start with rdy while in SCAN and counter != 0: overrun=1 for one cycle; trackers clear; the sample is processed as bin 0 of the new frame; no peak_valid for the aborted frame.
- frame_start and frame end in the same accepted sample cannot occur (frame_start forces bin 0).
- Back-to-back frames: frame_start&&rdy on the cycle that peak_valid is high is accepted as bin 0 of the next frame with no sample loss.
- Magnitudes compare unsigned at full MAG_W width; no truncation.

Test Plan:
Bench parameters for all scenarios: FFT_LOG2=4 (N=16), MIN_BIN=1, MAX_BIN=7, MAG_THRESH=0, rdy asserted on alternate cycles.
- Single peak: bin5 mag=1000 phase=0x01234; bin4=400; bin6=600; all other bins=10 -> peak_valid one cycle after bin15 accepted; peak_found=1, peak_bin=5, peak_mag=1000, peak_phase=0x01234, left=400, right=600; busy falls with peak_valid.
- Tie: bins 3 and 6 both 500, all others 10 -> peak_bin=3; left = bin2 magnitude; right = bin4 magnitude.
- Out-of-band rejection: bin0=9000, bin10=9000, bin2=50, all others 5 -> peak_bin=2, peak_mag=50.
- Empty frame: all 16 magnitudes 0 -> peak_valid pulses with peak_found=0 and every result output 0.
- Early restart: frame_start&&rdy at bin 8 -> overrun pulses once; no peak_valid until 16 further samples are accepted; the result reflects only the new frame. Separately, reset_n low at bin 9 -> all outputs 0, busy=0, and rdy without frame_start afterward is ignored.
